// File: rtl/sr_cmd_pkg.sv
// Shared types and default configuration for the SR command generator.
package sr_cmd_pkg;

    localparam int unsigned DB_CYCLES_DEF   = 4;
    localparam int unsigned HOLD_CYCLES_DEF = 2;
    localparam int unsigned CW_DEF          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        HOLD  = 2'd3
    } sr_cmd_state_t;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and command outputs of sr_cmd_gen.
interface sr_cmd_gen_if;

    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_in, clr_in,
        input  s, r, busy, conflict
    );

    modport slave (
        input  set_in, clr_in,
        output s, r, busy, conflict
    );

endinterface

// File: rtl/sr_debounce.sv
// Synchronizer + optional debouncer (SR_CMD_DEBOUNCE_EN) + rising-edge detector.
// rise is a combinational one-cycle pulse on each rising debounced edge.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CW        = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    if ((DB_CYCLES < 1) || (DB_CYCLES >= (2 ** CW))) begin : g_bad_cfg
        $error("sr_debounce: DB_CYCLES must be >= 1 and fit in CW bits");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef SR_CMD_DEBOUNCE_EN
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips only after DB_CYCLES consecutive mismatching cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = db_q;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncy push buttons into exclusive one-cycle s / r pulses for sr_ff.
// Define SR_CMD_DEBOUNCE_EN to include the debouncers; otherwise inputs are only synchronized.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned CW          = CW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sr_cmd_gen_if.slave  bus
);

    logic set_req;
    logic clr_req;

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_set_db (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.set_in),
        .rise (set_req)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_clr_db (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.clr_in),
        .rise (clr_req)
    );

    sr_cmd_state_t state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          busy_q, busy_d;
    logic          conflict_q, conflict_d;

    // Requests are only accepted in IDLE; outputs are decoded from the next state.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        conflict_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (set_req && clr_req) begin
                    conflict_d = 1'b1;
                end else if (set_req) begin
                    state_d = SET_P;
                end else if (clr_req) begin
                    state_d = CLR_P;
                end
            end
            SET_P, CLR_P: begin
                hold_d  = '0;
                state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (hold_q == CW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        s_d    = (state_d == SET_P);
        r_d    = (state_d == CLR_P);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;

endmodule
